// File: rtl/vmem_write_ctrl.sv
// Write-port arbiter for the 8192x15 video memory: CPU writes take priority over a
// row-major rectangle-fill engine, all outputs registered in the clkb domain.
module vmem_write_ctrl #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30,
    parameter int unsigned AW   = 13,
    parameter int unsigned DW   = 15
) (
    input  logic          clkb,
    input  logic          rst_n,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    input  logic          fill_start,
    input  logic          fill_abort,
    input  logic [6:0]    fill_x0,
    input  logic [5:0]    fill_y0,
    input  logic [7:0]    fill_w,
    input  logic [6:0]    fill_h,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_web
);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    localparam logic [8:0] ColsX = 9'(COLS);
    localparam logic [7:0] RowsY = 8'(ROWS);

    state_e        state_q, state_d;
    logic [6:0]    x_q, x_d;
    logic [6:0]    x0_q, x0_d;
    logic [5:0]    y_q, y_d;
    logic [7:0]    x_end_q, x_end_d;
    logic [6:0]    y_end_q, y_end_d;
    logic [DW-1:0] color_q, color_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          web_q, web_d;
    logic          done_q, done_d;

    logic [8:0]    x_sum;
    logic [7:0]    y_sum;
    logic          empty;
    logic          issue;
    logic          row_end;
    logic          last_cell;

    always_comb begin
        // One spare bit so x0+w / y0+h cannot wrap before clipping.
        x_sum     = {2'b00, fill_x0} + {1'b0, fill_w};
        y_sum     = {2'b00, fill_y0} + {1'b0, fill_h};
        empty     = (fill_w == 8'd0) || (fill_h == 7'd0) ||
                    ({2'b00, fill_x0} >= ColsX) || ({2'b00, fill_y0} >= RowsY);
        row_end   = (({1'b0, x_q} + 8'd1) == x_end_q);
        last_cell = row_end && (({1'b0, y_q} + 7'd1) == y_end_q);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        x0_d    = x0_q;
        y_d     = y_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        color_d = color_q;
        done_d  = 1'b0;
        issue   = 1'b0;

        case (state_q)
            StIdle: begin
                if (fill_start && !fill_abort) begin
                    color_d = fill_color;
                    x0_d    = fill_x0;
                    x_d     = fill_x0;
                    y_d     = fill_y0;
                    x_end_d = (x_sum > ColsX) ? ColsX[7:0] : x_sum[7:0];
                    y_end_d = (y_sum > {1'b0, RowsY}) ? RowsY[6:0] : y_sum[6:0];
                    if (empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (fill_abort) begin
                    state_d = StIdle;
                end else if (!cpu_wr) begin
                    issue = 1'b1;
                    if (last_cell) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (row_end) begin
                        x_d = x0_q;
                        y_d = y_q + 6'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        web_d   = 1'b0;
        if (cpu_wr) begin
            waddr_d = cpu_addr;
            wdata_d = cpu_data;
            web_d   = 1'b1;
        end else if (issue) begin
            waddr_d = AW'({y_q, x_q});
            wdata_d = color_q;
            web_d   = 1'b1;
        end
    end

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            x0_q    <= '0;
            y_q     <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            color_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            web_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            x0_q    <= x0_d;
            y_q     <= y_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            color_q <= color_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            web_q   <= web_d;
            done_q  <= done_d;
        end
    end

    assign fill_busy = (state_q == StFill);
    assign fill_done = done_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign mem_web   = web_q;

endmodule

// File: tb/tb_vmem_write_ctrl.sv
// Self-checking bench for vmem_write_ctrl: per-cycle comparison against a queue-based
// reference model, a table of fill rectangles, hand-written corner sequences and random traffic.
module tb_vmem_write_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clkb = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [14:0] cpu_data = '0;
    logic        fill_start = 1'b0;
    logic        fill_abort = 1'b0;
    logic [6:0]  fill_x0 = '0;
    logic [5:0]  fill_y0 = '0;
    logic [7:0]  fill_w = '0;
    logic [6:0]  fill_h = '0;
    logic [14:0] fill_color = '0;
    logic        fill_busy;
    logic        fill_done;
    logic [12:0] mem_waddr;
    logic [14:0] mem_wdata;
    logic        mem_web;

    vmem_write_ctrl dut (
        .clkb       (clkb),
        .rst_n      (rst_n),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_web    (mem_web)
    );

    always #5 clkb = ~clkb;

    int checks = 0;
    int errors = 0;

    // Reference model: a fill is just the list of cells still to be written.
    bit          m_busy = 1'b0;
    int unsigned m_q[$];
    logic [14:0] m_color = '0;
    logic [12:0] e_addr = '0;
    logic [14:0] e_data = '0;
    logic        e_web = 1'b0;
    logic        e_done = 1'b0;

    int          nwr;
    int          done_cnt;
    bit          done_on_wr;
    bit          busy_seen;
    logic [12:0] first_a;
    logic [12:0] last_a;

    typedef struct {
        logic [6:0]  x0;
        logic [5:0]  y0;
        logic [7:0]  w;
        logic [6:0]  h;
        logic [14:0] color;
        int          n;
        logic [12:0] first;
        logic [12:0] last;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = 1'b0;
        m_q.delete();
        m_color = '0;
        e_addr = '0;
        e_data = '0;
        e_web = 1'b0;
        e_done = 1'b0;
    endfunction

    function automatic void model_edge();
        bit          issue;
        logic [12:0] ia;
        int          xe;
        int          ye;
        issue = 1'b0;
        ia = '0;
        e_done = 1'b0;
        if (!m_busy) begin
            if (fill_start && !fill_abort) begin
                xe = int'(fill_x0) + int'(fill_w);
                ye = int'(fill_y0) + int'(fill_h);
                if (xe > COLS) xe = COLS;
                if (ye > ROWS) ye = ROWS;
                m_q.delete();
                for (int y = int'(fill_y0); y < ye; y++)
                    for (int x = int'(fill_x0); x < xe; x++)
                        m_q.push_back(y * 128 + x);
                m_color = fill_color;
                if (m_q.size() == 0) e_done = 1'b1;
                else m_busy = 1'b1;
            end
        end else if (fill_abort) begin
            m_busy = 1'b0;
            m_q.delete();
        end else if (!cpu_wr) begin
            issue = 1'b1;
            ia = 13'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end
        end
        if (cpu_wr) begin
            e_addr = cpu_addr;
            e_data = cpu_data;
            e_web = 1'b1;
        end else if (issue) begin
            e_addr = ia;
            e_data = m_color;
            e_web = 1'b1;
        end else begin
            e_web = 1'b0;
        end
    endfunction

    task automatic clear_stats();
        nwr = 0;
        done_cnt = 0;
        done_on_wr = 1'b0;
        busy_seen = 1'b0;
        first_a = '0;
        last_a = '0;
    endtask

    task automatic step();
        @(posedge clkb);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check("cycle", 64'({mem_web, fill_done, fill_busy, mem_waddr, mem_wdata}),
              64'({e_web, e_done, m_busy, e_addr, e_data}));
        if (mem_web) begin
            if (nwr == 0) first_a = mem_waddr;
            last_a = mem_waddr;
            nwr++;
        end
        if (fill_done) begin
            done_cnt++;
            done_on_wr = mem_web;
        end
        if (fill_busy) busy_seen = 1'b1;
    endtask

    task automatic start_fill(input logic [6:0] x0, input logic [5:0] y0, input logic [7:0] w,
                              input logic [6:0] h, input logic [14:0] color);
        fill_x0 = x0;
        fill_y0 = y0;
        fill_w = w;
        fill_h = h;
        fill_color = color;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) step();
        check("done_seen", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        vecs.push_back('{7'd0,  6'd0,  8'd80,  7'd30,  15'h0000, 2400, 13'h0000, 13'h0ECF});
        vecs.push_back('{7'd78, 6'd28, 8'd5,   7'd5,   15'h1ABC, 4,    13'h0E4E, 13'h0ECF});
        vecs.push_back('{7'd10, 6'd2,  8'd3,   7'd2,   15'h7FFF, 6,    13'h010A, 13'h018C});
        vecs.push_back('{7'd0,  6'd29, 8'd255, 7'd127, 15'h2222, 80,   13'h0E80, 13'h0ECF});
        vecs.push_back('{7'd5,  6'd7,  8'd1,   7'd1,   15'h0555, 1,    13'h0385, 13'h0385});
        vecs.push_back('{7'd10, 6'd2,  8'd0,   7'd5,   15'h1111, 0,    13'h0000, 13'h0000});
        vecs.push_back('{7'd10, 6'd2,  8'd4,   7'd0,   15'h1111, 0,    13'h0000, 13'h0000});
        vecs.push_back('{7'd80, 6'd0,  8'd4,   7'd3,   15'h1111, 0,    13'h0000, 13'h0000});
        vecs.push_back('{7'd0,  6'd30, 8'd4,   7'd3,   15'h1111, 0,    13'h0000, 13'h0000});
        vecs.push_back('{7'd127, 6'd63, 8'd255, 7'd127, 15'h1111, 0,   13'h0000, 13'h0000});

        clear_stats();
        model_reset();
        step();
        step();
        check("reset_state", 64'({mem_web, fill_done, fill_busy, mem_waddr, mem_wdata}), 64'd0);
        #2 rst_n = 1'b1;
        step();

        // Single CPU write: visible the next cycle, gone the one after.
        cpu_wr = 1'b1;
        cpu_addr = 13'h0123;
        cpu_data = 15'h7FFF;
        step();
        cpu_wr = 1'b0;
        check("cpu_web", 64'(mem_web), 64'd1);
        check("cpu_addr", 64'(mem_waddr), 64'h0123);
        check("cpu_data", 64'(mem_wdata), 64'h7FFF);
        step();
        check("cpu_web_off", 64'(mem_web), 64'd0);

        foreach (vecs[i]) begin
            clear_stats();
            start_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color);
            wait_done(3000);
            step();
            check("tbl_nwr", 64'(nwr), 64'(vecs[i].n));
            check("tbl_busy_seen", 64'(busy_seen), 64'(vecs[i].n > 0));
            check("tbl_busy_after", 64'(fill_busy), 64'd0);
            if (vecs[i].n > 0) begin
                check("tbl_first", 64'(first_a), 64'(vecs[i].first));
                check("tbl_last", 64'(last_a), 64'(vecs[i].last));
                check("tbl_done_on_wr", 64'(done_on_wr), 64'd1);
            end
        end

        // CPU contention for three cycles in the middle of a fill.
        clear_stats();
        start_fill(7'd10, 6'd2, 8'd6, 7'd2, 15'h1234);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1'b1;
            cpu_addr = 13'(13'h1000 + i);
            cpu_data = 15'(15'h4000 + i);
            step();
        end
        cpu_wr = 1'b0;
        wait_done(100);
        check("contend_nwr", 64'(nwr), 64'd15);

        // Abort after five fill writes.
        clear_stats();
        start_fill(7'd0, 6'd0, 8'd80, 7'd30, 15'h0AAA);
        for (int i = 0; i < 20 && nwr < 5; i++) step();
        fill_abort = 1'b1;
        step();
        fill_abort = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("abort_nwr", 64'(nwr), 64'd5);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle", 64'(fill_busy), 64'd0);

        // A second start while busy is ignored.
        clear_stats();
        start_fill(7'd0, 6'd0, 8'd4, 7'd2, 15'h0F0F);
        step();
        fill_x0 = 7'd0;
        fill_y0 = 6'd10;
        fill_w = 8'd50;
        fill_h = 7'd5;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        wait_done(100);
        step();
        check("restart_nwr", 64'(nwr), 64'd8);

        // Asynchronous reset mid-fill.
        clear_stats();
        start_fill(7'd0, 6'd0, 8'd80, 7'd30, 15'h7777);
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({mem_web, fill_done, fill_busy, mem_waddr, mem_wdata}), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 20; i++) step();
        check("post_reset_nwr", 64'(nwr), 64'd0);
        check("post_reset_done", 64'(done_cnt), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cpu_wr = ($urandom_range(0, 4) == 0);
            cpu_addr = 13'($urandom);
            cpu_data = 15'($urandom);
            fill_start = ($urandom_range(0, 9) == 0);
            fill_abort = ($urandom_range(0, 80) == 0);
            fill_x0 = 7'($urandom_range(0, 90));
            fill_y0 = 6'($urandom_range(0, 33));
            fill_w = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            fill_h = 7'($urandom_range(0, 6));
            fill_color = 15'($urandom);
            step();
        end
        cpu_wr = 1'b0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmem_write_ctrl.md
Name: vmem_write_ctrl

Overview:
- Owns the write port of the 8192x15 video memory that feeds the character-cell display.
- Merges two write sources:
  - single-cycle CPU writes from the MIPS bus;
  - a hardware rectangle-fill engine used for clear-screen and box drawing.
- CPU writes always win; the fill engine stalls for any cycle in which the CPU writes.
- Output port drives the vmem write side (addrb/datab/web) directly, in the clkb domain.

Parameters:
- COLS, 80, visible cell columns (x range 0..COLS-1, x is 7 bits).
- ROWS, 30, visible cell rows (y range 0..ROWS-1, y is 6 bits).
- AW, 13, vmem address width; address = {y[5:0], x[6:0]}.
- DW, 15, pixel word width, RGB555 as {r[4:0], g[4:0], b[4:0]}.

Ports:
- clkb  in  1  write-side clock
- rst_n  in  1  asynchronous active-low reset
- cpu_wr  in  1  CPU write strobe, one write per cycle high, always accepted
- cpu_addr  in  AW  CPU write address
- cpu_data  in  DW  CPU write data
- fill_start  in  1  start pulse, sampled only in IDLE
- fill_abort  in  1  abort current fill
- fill_x0  in  7  rectangle left column
- fill_y0  in  6  rectangle top row
- fill_w  in  8  width in cells
- fill_h  in  7  height in cells
- fill_color  in  DW  fill word
- fill_busy  out  1  high while state is FILL
- fill_done  out  1  one-cycle completion pulse
- mem_waddr  out  AW  vmem write address (registered)
- mem_wdata  out  DW  vmem write data (registered)
- mem_web  out  1  vmem write enable (registered)

Behaviour:
- Reset (async, rst_n low): state IDLE; mem_waddr=0, mem_wdata=0, mem_web=0, fill_busy=0, fill_done=0; internal counters cleared.
- Reset mid-fill kills the fill immediately: no further writes and no fill_done.
- Clock and reset: single clock clkb; reset is asynchronous, active-low on rst_n.
- Output register:
  - Each cycle, the next {mem_waddr, mem_wdata, mem_web} is selected in priority order:
    1. cpu_wr=1 -> {cpu_addr, cpu_data, 1};
    2. else FILL-state engine issue -> {{y,x}, color_q, 1};
    3. else mem_web=0 and address/data hold.
  - CPU write latency is 1 cycle: cpu_wr high in cycle T gives mem_web high in T+1.
- State machine (IDLE, FILL):
  - IDLE, fill_start=1 and fill_abort=0 in cycle T:
    - latch color_q, x0, x_end=min(x0+w, COLS), y_end=min(y0+h, ROWS); set x=x0, y=y0.
    - If the rectangle is empty (w=0, h=0, x0>=COLS or y0>=ROWS): stay IDLE, pulse fill_done in T+1, no writes.
    - Otherwise: enter FILL at end of T, fill_busy high from T+1.
  - FILL, each cycle:
    - If fill_abort=1: go to IDLE at end of cycle; issue nothing; no fill_done.
    - Else if cpu_wr=1: stall; x, y and state hold.
    - Else issue the write at (x, y), then advance row-major: x+1; when x+1==x_end, x=x0 and y+1.
    - When the issued cell is (x_end-1, y_end-1): go to IDLE; fill_done pulses in the same cycle that the last write shows on mem_web.
  - fill_start while in FILL is ignored.
  - Parameter inputs are only sampled on an accepted start; changing them mid-fill has no effect.
- Throughput and ordering:
  - First fill write appears on mem_web in T+2 when uncontended.
  - Total fill writes = (x_end-x0)*(y_end-y0), each cell written exactly once, in row-major order.
- Arithmetic: x0+w and y0+h are computed with one extra bit to avoid wrap before the min; addresses never exceed {ROWS-1, COLS-1}.

Test Plan:
- Reset: assert rst_n=0 mid-fill -> all outputs 0 asynchronously; after release, no writes and no fill_done until a new start.
- CPU write only: cpu_wr=1, addr=0x0123, data=0x7FFF at T -> mem_web=1, mem_waddr=0x0123, mem_wdata=0x7FFF at T+1; mem_web=0 at T+2.
- Full clear: start x0=0, y0=0, w=80, h=30, color=0 ->
  - exactly 2400 writes, first at address 0x0000, last at {29,79}=0x0ECF;
  - fill_done in the same cycle as the last write; fill_busy low the cycle after.
- Clipping: start x0=78, y0=28, w=5, h=5 -> writes in order {28,78}, {28,79}, {29,78}, {29,79}; 4 writes total, then fill_done.
- Contention: during a fill at x0=10, y0=2, assert cpu_wr for 3 consecutive cycles ->
  - the 3 CPU writes appear on consecutive cycles;
  - the fill resumes at the exact next cell; no cell is skipped or duplicated.
- Edge cases:
  - start with w=0 -> fill_done in T+1, fill_busy never high, no mem_web.
  - fill_abort after 5 fill writes -> IDLE, no further writes, no fill_done.
  - fill_start while busy -> ignored.
